// File: rtl/gb_mdu_pkg.sv
// Shared definitions for the gb_mdu multiply/divide unit: funct3 op codes,
// FSM state encodings and operand-signedness helpers.
package gb_mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Word-form multiplies all collapse to MULW, so both operands count as signed there.
  function automatic logic op1_is_signed(mdu_op_e op, logic w32);
    return (w32 && !op[2]) || !(op inside {OP_MULHU, OP_DIVU, OP_REMU});
  endfunction

  function automatic logic op2_is_signed(mdu_op_e op, logic w32);
    return (w32 && !op[2]) || (op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
  endfunction

  function automatic logic op_is_high(mdu_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic op_is_quot(mdu_op_e op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/gb_mdu_if.sv
// Request/response handshake bundle between the execute stage and gb_mdu.
interface gb_mdu_if #(
  parameter int XLEN = 64
);

  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_op;
  logic            i_sig_w32;
  logic [XLEN-1:0] i_op1;
  logic [XLEN-1:0] i_op2;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_res;

  modport slave (
    input  i_valid, i_op, i_sig_w32, i_op1, i_op2, i_flush, i_ready,
    output o_ready, o_valid, o_res
  );

  modport master (
    output i_valid, i_op, i_sig_w32, i_op1, i_op2, i_flush, i_ready,
    input  o_ready, o_valid, o_res
  );

endinterface

// File: rtl/gb_mdu_divstep.sv
// One restoring-division step: shift in the next dividend bit and subtract the
// divisor when it fits. Relies on rem_i < div_i, which the iteration maintains.
module gb_mdu_divstep #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] div_i,
  input  logic            bit_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);

  logic [XLEN:0] part;
  logic [XLEN:0] diff;

  always_comb begin
    part  = {rem_i, bit_i};
    diff  = part - {1'b0, div_i};
    // The top bit of the difference is the borrow: clear means the divisor fitted.
    q_o   = ~diff[XLEN];
    rem_o = q_o ? diff[XLEN-1:0] : part[XLEN-1:0];
  end

endmodule

// File: rtl/gb_mdu.sv
// Iterative M-extension multiply/divide unit: one bit per cycle shift-add multiply and
// restoring divide on operand magnitudes, with a final sign/width fix-up cycle.
module gb_mdu
  import gb_mdu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter bit EN_W32 = 1'b1
) (
  input logic     i_clk,
  input logic     i_rst,
  gb_mdu_if.slave bus
);

  localparam int CNT_W  = $clog2(XLEN);
  localparam bit W32_OK = EN_W32 && (XLEN == 64);

  function automatic logic [XLEN-1:0] ext32(logic [XLEN-1:0] x, logic sgn);
    logic [XLEN-1:0] r;
    r = x;
    for (int i = 32; i < XLEN; i++) r[i] = sgn & x[31];
    return r;
  endfunction

  function automatic logic [XLEN-1:0] cond_neg(logic [XLEN-1:0] x, logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mag1_q, mag1_d;
  logic [XLEN-1:0]   mag2_q, mag2_d;
  mdu_op_e           op_q, op_d;
  logic              w32_q, w32_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   res_q, res_d;

  // Request decode: width selection, operand extension, magnitudes, special divides
  mdu_op_e         op_in;
  logic            w32_in, zext_in, neg1_in, neg2_in, rneg_in;
  logic [XLEN-1:0] a_ext, b_ext, m1_in, m2_in, min_n, spec_res;
  logic            div0_in, ovf_in;

  always_comb begin
    op_in   = mdu_op_e'(bus.i_op);
    w32_in  = W32_OK & bus.i_sig_w32;
    zext_in = op_in inside {OP_DIVU, OP_REMU};
    a_ext   = w32_in ? ext32(bus.i_op1, ~zext_in) : bus.i_op1;
    b_ext   = w32_in ? ext32(bus.i_op2, ~zext_in) : bus.i_op2;
    neg1_in = op1_is_signed(op_in, w32_in) & a_ext[XLEN-1];
    neg2_in = op2_is_signed(op_in, w32_in) & b_ext[XLEN-1];
    m1_in   = cond_neg(a_ext, neg1_in);
    m2_in   = cond_neg(b_ext, neg2_in);
    rneg_in = (op_in == OP_REM) ? neg1_in : (neg1_in ^ neg2_in);

    min_n = '0;
    if (w32_in) min_n = ext32(XLEN'(32'h8000_0000), 1'b1);
    else        min_n[XLEN-1] = 1'b1;

    div0_in = op_in[2] && (b_ext == '0);
    ovf_in  = (op_in inside {OP_DIV, OP_REM}) && (a_ext == min_n) && (b_ext == '1);

    if (div0_in)             spec_res = op_is_quot(op_in) ? '1 : a_ext;
    else if (op_is_quot(op_in)) spec_res = a_ext;
    else                     spec_res = '0;
    if (w32_in) spec_res = ext32(spec_res, 1'b1);
  end

  // Iteration datapath: multiplier/dividend bits are consumed MSB first
  logic [XLEN-1:0]   step_rem;
  logic              step_q;
  logic [2*XLEN-1:0] mul_next, div_next;

  gb_mdu_divstep #(.XLEN(XLEN)) u_divstep (
    .rem_i (acc_q[2*XLEN-1:XLEN]),
    .div_i (mag2_q),
    .bit_i (mag1_q[cnt_q]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    mul_next = (acc_q << 1) + (mag2_q[cnt_q] ? {{XLEN{1'b0}}, mag1_q} : '0);
    div_next = {step_rem, acc_q[XLEN-2:0], step_q};
  end

  // Fix-up: sign restore, half selection and word sign-extension
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_sel, div_sel, fix_res;

  always_comb begin
    prod    = neg_q ? (~acc_q + 1'b1) : acc_q;
    mul_sel = (!w32_q && op_is_high(op_q)) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    div_sel = op_is_quot(op_q) ? acc_q[XLEN-1:0] : acc_q[2*XLEN-1:XLEN];
    div_sel = cond_neg(div_sel, neg_q);
    fix_res = op_q[2] ? div_sel : mul_sel;
    if (w32_q) fix_res = ext32(fix_res, 1'b1);
  end

  // Control FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mag1_d  = mag1_q;
    mag2_d  = mag2_q;
    op_d    = op_q;
    w32_d   = w32_q;
    neg_d   = neg_q;
    res_d   = res_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid && !bus.i_flush) begin
          op_d   = op_in;
          w32_d  = w32_in;
          neg_d  = rneg_in;
          mag1_d = m1_in;
          mag2_d = m2_in;
          acc_d  = '0;
          cnt_d  = w32_in ? CNT_W'(31) : CNT_W'(XLEN - 1);
          if (div0_in || ovf_in) begin
            res_d   = spec_res;
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_FIX: begin
        res_d   = fix_res;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A flush drops whatever is in flight and keeps the previous result untouched.
    if (bus.i_flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      res_d   = res_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mag1_q  <= '0;
      mag2_q  <= '0;
      op_q    <= OP_MUL;
      w32_q   <= 1'b0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mag1_q  <= mag1_d;
      mag2_q  <= mag2_d;
      op_q    <= op_d;
      w32_q   <= w32_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  assign bus.o_ready = (state_q == ST_IDLE);
  assign bus.o_valid = (state_q == ST_DONE);
  assign bus.o_res   = res_q;

endmodule
